// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control path: FSM states, opcodes,
// ALU FUNCT codes, flagALU classes and the decoded-instruction record.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [5:0] OP_R_ALU = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_SUBI  = 6'd2;
    localparam logic [5:0] OP_ANDI  = 6'd3;
    localparam logic [5:0] OP_SRL   = 6'd4;
    localparam logic [5:0] OP_SLL   = 6'd5;
    localparam logic [5:0] OP_BEQ   = 6'd6;
    localparam logic [5:0] OP_BNE   = 6'd7;
    localparam logic [5:0] OP_ORI   = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd9;
    localparam logic [5:0] OP_SW    = 6'd10;
    localparam logic [5:0] OP_J     = 6'd11;
    localparam logic [5:0] OP_HALT  = 6'd12;

    localparam logic [5:0] FN_ADD  = 6'd0;
    localparam logic [5:0] FN_ADDI = 6'd1;
    localparam logic [5:0] FN_SUBI = 6'd3;
    localparam logic [5:0] FN_ANDI = 6'd5;
    localparam logic [5:0] FN_ORI  = 6'd7;

    localparam logic [1:0] CLS_IDLE   = 2'd0;
    localparam logic [1:0] CLS_FUNCT  = 2'd1;
    localparam logic [1:0] CLS_OPCODE = 2'd2;

    typedef enum logic [2:0] {
        K_ALU, K_BRANCH, K_LOAD, K_STORE, K_JUMP, K_HALT, K_ILLEGAL
    } kind_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [1:0]  cls;
        logic        reg_dst;
        kind_t       kind;
    } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into ALU controls,
// register addresses, sign-extended immediate and instruction kind.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output decode_t     dec
);

    always_comb begin
        dec.opcode  = ir[31:26];
        dec.funct   = ir[5:0];
        dec.rs      = ir[25:21];
        dec.rt      = ir[20:16];
        dec.rd      = ir[15:11];
        dec.shamt   = ir[10:6];
        dec.imm     = {{16{ir[15]}}, ir[15:0]};
        dec.cls     = CLS_IDLE;
        dec.reg_dst = 1'b0;
        dec.kind    = K_ILLEGAL;
        case (ir[31:26])
            OP_R_ALU: begin
                dec.cls = CLS_FUNCT; dec.reg_dst = 1'b1; dec.kind = K_ALU;
            end
            OP_ADDI: begin dec.funct = FN_ADDI; dec.cls = CLS_FUNCT; dec.kind = K_ALU; end
            OP_SUBI: begin dec.funct = FN_SUBI; dec.cls = CLS_FUNCT; dec.kind = K_ALU; end
            OP_ANDI: begin dec.funct = FN_ANDI; dec.cls = CLS_FUNCT; dec.kind = K_ALU; end
            OP_ORI:  begin dec.funct = FN_ORI;  dec.cls = CLS_FUNCT; dec.kind = K_ALU; end
            OP_SRL, OP_SLL: begin
                dec.cls = CLS_OPCODE; dec.reg_dst = 1'b1; dec.kind = K_ALU;
            end
            OP_BEQ, OP_BNE: begin dec.cls = CLS_OPCODE; dec.kind = K_BRANCH; end
            // Loads and stores borrow ADDI to form the address rs + imm.
            OP_LW:   begin dec.funct = FN_ADDI; dec.cls = CLS_FUNCT; dec.kind = K_LOAD; end
            OP_SW:   begin dec.funct = FN_ADDI; dec.cls = CLS_FUNCT; dec.kind = K_STORE; end
            OP_J:    dec.kind = K_JUMP;
            OP_HALT: dec.kind = K_HALT;
            default: dec.kind = K_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control stage: owns PC and IR, fetches over a ready handshake
// and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with registered outputs.
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int bits   = 32,
    parameter int bitsOP = 6,
    parameter int bitsS  = 5,
    parameter int st     = 3,
    parameter int pcW    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [bits-1:0]   mem_rdata,
    input  logic              mem_ready,
    input  logic              flagBRANCH,
    output logic [pcW-1:0]    pc,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_addr_sel,
    output logic [st-1:0]     State,
    output logic [1:0]        flagALU,
    output logic [bitsOP-1:0] OPCODE,
    output logic [bitsOP-1:0] FUNCT,
    output logic [bitsS-1:0]  shamt,
    output logic [bits-1:0]   immediate,
    output logic [bitsS-1:0]  rs_addr,
    output logic [bitsS-1:0]  rt_addr,
    output logic [bitsS-1:0]  rd_addr,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              halted,
    output logic              illegal
);

    state_t          state;
    kind_t           kind_q;
    logic [bits-1:0] ir;
    decode_t         dec;

    instr_decoder u_dec (
        .ir  (ir),
        .dec (dec)
    );

    assign State = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            kind_q       <= K_ALU;
            pc           <= '0;
            ir           <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr_sel <= 1'b0;
            flagALU      <= CLS_IDLE;
            OPCODE       <= '0;
            FUNCT        <= '0;
            shamt        <= '0;
            immediate    <= '0;
            rs_addr      <= '0;
            rt_addr      <= '0;
            rd_addr      <= '0;
            reg_write    <= 1'b0;
            reg_dst      <= 1'b0;
            mem_to_reg   <= 1'b0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            // Strobes are one-cycle unless the next state re-asserts them.
            reg_write    <= 1'b0;
            illegal      <= 1'b0;
            flagALU      <= CLS_IDLE;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr_sel <= 1'b0;
            mem_to_reg   <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + pcW'(1);
                        state <= S_DECODE;
                    end else begin
                        mem_read <= 1'b1;
                    end
                end
                S_DECODE: begin
                    OPCODE    <= dec.opcode;
                    FUNCT     <= dec.funct;
                    shamt     <= dec.shamt;
                    immediate <= dec.imm;
                    rs_addr   <= dec.rs;
                    rt_addr   <= dec.rt;
                    rd_addr   <= dec.rd;
                    reg_dst   <= dec.reg_dst;
                    kind_q    <= dec.kind;
                    case (dec.kind)
                        K_JUMP: begin
                            pc       <= dec.imm[pcW-1:0];
                            state    <= S_FETCH;
                            mem_read <= 1'b1;
                        end
                        K_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        K_ILLEGAL: begin
                            illegal  <= 1'b1;
                            state    <= S_FETCH;
                            mem_read <= 1'b1;
                        end
                        default: begin
                            state   <= S_EXECUTE;
                            flagALU <= dec.cls;
                        end
                    endcase
                end
                S_EXECUTE: begin
                    if (kind_q == K_LOAD || kind_q == K_STORE) begin
                        state        <= S_MEMORY;
                        mem_addr_sel <= 1'b1;
                        mem_read     <= (kind_q == K_LOAD);
                        mem_write    <= (kind_q == K_STORE);
                    end else begin
                        state     <= S_WRITEBACK;
                        reg_write <= (kind_q == K_ALU);
                    end
                end
                S_MEMORY: begin
                    if (!mem_ready) begin
                        mem_addr_sel <= 1'b1;
                        mem_read     <= (kind_q == K_LOAD);
                        mem_write    <= (kind_q == K_STORE);
                    end else if (kind_q == K_LOAD) begin
                        state      <= S_WRITEBACK;
                        reg_write  <= 1'b1;
                        mem_to_reg <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        mem_read <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    // pc already points past the branch, so the offset is relative to pc+1.
                    if (kind_q == K_BRANCH && flagBRANCH)
                        pc <= pc + immediate[pcW-1:0];
                    state    <= S_FETCH;
                    mem_read <= 1'b1;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: instruction-level reference model predicting the
// per-cycle state, strobes, PC and decoded fields for directed and random programs.
module tb_multicycle_control_unit;

    logic        clock;
    logic        reset;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        flagBRANCH;
    logic [15:0] pc;
    logic        mem_read, mem_write, mem_addr_sel;
    logic [2:0]  State;
    logic [1:0]  flagALU;
    logic [5:0]  OPCODE, FUNCT;
    logic [4:0]  shamt, rs_addr, rt_addr, rd_addr;
    logic [31:0] immediate;
    logic        reg_write, reg_dst, mem_to_reg, halted, illegal;

    int checks;
    int errors;
    int cycles;

    logic [15:0] mpc;
    bit          mhalted;
    bit          pend_ill;
    bit          after_reset;

    multicycle_control_unit #(.bits(32), .bitsOP(6), .bitsS(5), .st(3), .pcW(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .flagBRANCH   (flagBRANCH),
        .pc           (pc),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr_sel (mem_addr_sel),
        .State        (State),
        .flagALU      (flagALU),
        .OPCODE       (OPCODE),
        .FUNCT        (FUNCT),
        .shamt        (shamt),
        .immediate    (immediate),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rd_addr      (rd_addr),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .halted       (halted),
        .illegal      (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic int exp_cls(input int op);
        return (op >= 4 && op <= 7) ? 2 : 1;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [5:0]  o;
        logic [31:0] r;
        int s;
        s = $urandom_range(0, 12);
        o = (s < 12) ? 6'(s) : 6'($urandom_range(13, 63));
        r = $urandom;
        return {o, r[25:0]};
    endfunction

    task automatic chk_reset();
        check("rst State", State, 0);
        check("rst pc", pc, 0);
        check("rst mem_read", mem_read, 0);
        check("rst mem_write", mem_write, 0);
        check("rst mem_addr_sel", mem_addr_sel, 0);
        check("rst flagALU", flagALU, 0);
        check("rst OPCODE", OPCODE, 0);
        check("rst FUNCT", FUNCT, 0);
        check("rst shamt", shamt, 0);
        check("rst immediate", immediate, 0);
        check("rst rs_addr", rs_addr, 0);
        check("rst rt_addr", rt_addr, 0);
        check("rst rd_addr", rd_addr, 0);
        check("rst reg_write", reg_write, 0);
        check("rst reg_dst", reg_dst, 0);
        check("rst mem_to_reg", mem_to_reg, 0);
        check("rst halted", halted, 0);
        check("rst illegal", illegal, 0);
    endtask

    // Check the current cycle's outputs, then drive inputs for its closing edge.
    task automatic cyc(input int es, input int ef, input bit erw, input bit emr, input bit emw,
                       input bit esel, input bit em2r, input bit eill,
                       input bit rdy, input bit fbr, input logic [31:0] rdata);
        check("State", State, es);
        check("flagALU", flagALU, ef);
        check("reg_write", reg_write, erw);
        check("mem_read", mem_read, emr);
        check("mem_write", mem_write, emw);
        check("mem_addr_sel", mem_addr_sel, esel);
        check("mem_to_reg", mem_to_reg, em2r);
        check("illegal", illegal, eill);
        check("pc", pc, mpc);
        check("halted", halted, mhalted);
        mem_ready  = rdy;
        flagBRANCH = fbr;
        mem_rdata  = rdata;
        @(negedge clock);
        cycles++;
        if (cycles > 50000) begin
            $display("FAIL cycle budget exceeded: observed %0d cycles, limit 50000", cycles);
            $fatal(1);
        end
    endtask

    task automatic chk_fields(input logic [31:0] ins);
        int op;
        op = int'(ins[31:26]);
        check("rs_addr", rs_addr, ins[25:21]);
        check("rt_addr", rt_addr, ins[20:16]);
        check("rd_addr", rd_addr, ins[15:11]);
        check("shamt", shamt, ins[10:6]);
        check("immediate", immediate, {{16{ins[15]}}, ins[15:0]});
        case (op)
            0:      begin check("FUNCT", FUNCT, ins[5:0]); check("reg_dst", reg_dst, 1); end
            1:      begin check("FUNCT", FUNCT, 1); check("reg_dst", reg_dst, 0); end
            2:      begin check("FUNCT", FUNCT, 3); check("reg_dst", reg_dst, 0); end
            3:      begin check("FUNCT", FUNCT, 5); check("reg_dst", reg_dst, 0); end
            8:      begin check("FUNCT", FUNCT, 7); check("reg_dst", reg_dst, 0); end
            4, 5:   begin check("OPCODE", OPCODE, op); check("reg_dst", reg_dst, 1); end
            6, 7:   check("OPCODE", OPCODE, op);
            9:      begin check("FUNCT", FUNCT, 1); check("reg_dst", reg_dst, 0); end
            default: check("FUNCT", FUNCT, 1);
        endcase
    endtask

    task automatic exec(input logic [31:0] ins, input int fw, input int mw, input int fb, input bit abort);
        int op;
        bit mr, ill, b;
        op = int'(ins[31:26]);
        mr = !after_reset;
        ill = pend_ill;
        after_reset = 0;
        pend_ill = 0;
        for (int i = 0; i < fw; i++) begin
            cyc(0, 0, 0, mr, 0, 0, 0, ill, 0, rb(), $urandom);
            mr = 1;
            ill = 0;
        end
        cyc(0, 0, 0, mr, 0, 0, 0, ill, 1, rb(), ins);
        mpc = mpc + 16'd1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, rb(), rb(), $urandom);
        if (op == 11) begin mpc = ins[15:0]; return; end
        if (op == 12) begin mhalted = 1; return; end
        if (op > 12)  begin pend_ill = 1; return; end
        chk_fields(ins);
        cyc(2, exp_cls(op), 0, 0, 0, 0, 0, 0, rb(), rb(), $urandom);
        if (op == 9 || op == 10) begin
            for (int i = 0; i < mw; i++) begin
                cyc(3, 0, 0, op == 9, op == 10, 1, 0, 0, 0, rb(), $urandom);
                if (abort) begin
                    check("pre-reset mem_write", mem_write, 1);
                    #2 reset = 1'b0;
                    #1;
                    chk_reset();
                    @(negedge clock);
                    chk_reset();
                    mem_ready = 1'b0;
                    reset = 1'b1;
                    after_reset = 1;
                    mpc = '0;
                    mhalted = 0;
                    pend_ill = 0;
                    return;
                end
            end
            cyc(3, 0, 0, op == 9, op == 10, 1, 0, 0, 1, rb(), $urandom);
            if (op == 10) return;
            cyc(4, 0, 1, 0, 0, 0, 1, 0, rb(), rb(), $urandom);
        end else if (op == 6 || op == 7) begin
            b = (fb == 2) ? rb() : (fb != 0);
            cyc(4, 0, 0, 0, 0, 0, 0, 0, rb(), b, $urandom);
            if (b) mpc = mpc + ins[15:0];
        end else begin
            cyc(4, 0, 1, 0, 0, 0, 0, 0, rb(), rb(), $urandom);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cycles = 0;
        reset = 1'b0; mem_ready = 1'b0; flagBRANCH = 1'b0; mem_rdata = '0;
        mpc = '0; mhalted = 0; pend_ill = 0; after_reset = 1;
        repeat (2) @(negedge clock);
        chk_reset();
        reset = 1'b1;

        exec({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0}, 0, 0, 0, 0);  // ADD r3, r1, r2
        check("pc after ADD", pc, 1);
        exec({6'd9, 5'd1, 5'd5, 16'd4}, 0, 3, 0, 0);               // LW r5, 4(r1)
        exec({6'd11, 10'd0, 16'd10}, 0, 0, 0, 0);                  // J 10
        exec({6'd6, 5'd1, 5'd2, 16'hFFFD}, 0, 0, 1, 0);            // BEQ -3 taken
        check("pc after taken BEQ", pc, 8);
        exec({6'd11, 10'd0, 16'd10}, 1, 0, 0, 0);
        exec({6'd6, 5'd1, 5'd2, 16'hFFFD}, 0, 0, 0, 0);            // BEQ -3 not taken
        check("pc after untaken BEQ", pc, 11);
        exec({6'd63, 26'h123}, 0, 0, 0, 0);                        // undefined opcode
        check("pc after illegal", pc, 12);
        check("illegal pulse", illegal, 1);

        repeat (200) exec(rand_ins(), $urandom_range(0, 2), $urandom_range(0, 2), 2, 0);

        exec({6'd10, 5'd2, 5'd7, 16'h0010}, 0, 2, 0, 1);           // SW aborted by reset

        repeat (50) exec(rand_ins(), $urandom_range(0, 2), $urandom_range(0, 2), 2, 0);

        exec({6'd11, 10'd0, 16'h0040}, 0, 0, 0, 0);
        check("pc after J 0x40", pc, 16'h0040);
        exec({6'd12, 26'd0}, 0, 0, 0, 0);
        check("halted set", halted, 1);
        repeat (20) cyc(5, 0, 0, 0, 0, 0, 0, 0, rb(), rb(), $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
